// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port SRAM between instruction fetch and the memory stage.
// MEM normally wins; a starving IF requester gets one forced-priority cycle.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_stall,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [3:0]  mem_w_en,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic [3:0]  sram_w_en,
    output logic [15:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic {ARB, FORCE_IF} state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [1:0]  tag_q, tag_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        gnt_if, gnt_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            starve_q    <= 4'd0;
            tag_q       <= 2'b00;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tag_q       <= tag_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Forced-IF priority lasts exactly one cycle regardless of what IF did with it.
    always_comb begin
        state_d = ARB;
        if (state_q == ARB && starve_d == 4'(STARVE_MAX)) begin
            state_d = FORCE_IF;
        end
    end

    always_comb begin
        gnt_if  = 1'b0;
        gnt_mem = 1'b0;
        if (state_q == FORCE_IF) begin
            gnt_if  = if_req;
            gnt_mem = mem_req && !if_req;
        end else begin
            gnt_mem = mem_req;
            gnt_if  = if_req && !mem_req;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        if (if_req && !gnt_if) begin
            starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
        end
    end

    always_comb begin
        sram_w_en  = 4'd0;
        sram_addr  = 16'd0;
        sram_wdata = 32'd0;
        if (gnt_mem) begin
            sram_w_en  = mem_w_en;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (gnt_if) begin
            sram_addr  = if_addr;
        end
    end

    // Read data returns one cycle after the grant; the tag remembers who is owed it.
    always_comb begin
        tag_d       = {gnt_if, gnt_mem && (mem_w_en == 4'd0)};
        if_rdata_d  = tag_q[1] ? sram_rdata : if_rdata_q;
        mem_rdata_d = tag_q[0] ? sram_rdata : mem_rdata_q;
    end

    assign if_stall   = if_req && !gnt_if;
    assign mem_stall  = mem_req && !gnt_mem;
    assign if_rvalid  = tag_q[1];
    assign mem_rvalid = tag_q[0];
    assign if_rdata   = if_rdata_d;
    assign mem_rdata  = mem_rdata_d;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_MAX, default 4, setting the number of consecutive denied IF-request cycles before IF is forced a grant (legal range 1-15).
REQ-002 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The module SHALL have port if_req  input  1  fetch stage requests an instruction read this cycle.
REQ-005 The module SHALL have port if_addr  input  16  fetch byte address.
REQ-006 The module SHALL have port if_stall  output  1  combinational; high when if_req is high and IF is not granted.
REQ-007 The module SHALL have port if_rvalid  output  1  registered; high one cycle after an IF grant.
REQ-008 The module SHALL have port if_rdata  output  32  instruction word; holds its value between valid pulses.
REQ-009 The module SHALL have port mem_req  input  1  memory stage requests an access this cycle.
REQ-010 The module SHALL have port mem_w_en  input  4  byte write enables; 4'b0000 means read.
REQ-011 The module SHALL have port mem_addr  input  16  data byte address.
REQ-012 The module SHALL have port mem_wdata  input  32  store data.
REQ-013 The module SHALL have port mem_stall  output  1  combinational; high when mem_req is high and MEM is not granted.
REQ-014 The module SHALL have port mem_rvalid  output  1  registered; high one cycle after a MEM read grant only.
REQ-015 The module SHALL have port mem_rdata  output  32  load word; holds its value between valid pulses.
REQ-016 The module SHALL have ports sram_w_en (output, 4), sram_addr (output, 16), sram_wdata (output, 32) and sram_rdata (input, 32), connecting to one single-port SRAM with 1-cycle synchronous read.

Function
REQ-017 The arbiter SHALL grant at most one requester per cycle; the grant is combinational from the current requests and the current state.
REQ-018 The FSM SHALL have two states: ARB (MEM has priority) and FORCE_IF (IF has priority).
REQ-019 In ARB, mem_req=1 SHALL grant MEM; otherwise if_req=1 SHALL grant IF.
REQ-020 In FORCE_IF, if_req=1 SHALL grant IF; otherwise mem_req=1 SHALL grant MEM.
REQ-021 A 4-bit starve counter SHALL increment on each cycle with if_req=1 and no IF grant, saturating at 15.
REQ-022 The starve counter SHALL clear on any IF grant and on any cycle with if_req=0.
REQ-023 The FSM SHALL move ARB->FORCE_IF on the edge at which the counter's next value equals STARVE_MAX.
REQ-024 The FSM SHALL move FORCE_IF->ARB after exactly one cycle, whether or not IF was granted.
REQ-025 On a MEM grant, sram_addr=mem_addr, sram_w_en=mem_w_en and sram_wdata=mem_wdata.
REQ-026 On an IF grant, sram_addr=if_addr, sram_w_en=0 and sram_wdata=0.
REQ-027 With no grant, sram_w_en SHALL be 0, sram_addr=0 and sram_wdata=0.
REQ-028 A 2-bit return tag SHALL be registered each edge: {IF read granted, MEM read granted}.
REQ-029 In the cycle after the tag is set, the flagged rvalid SHALL assert and the matching rdata register SHALL capture sram_rdata; the capture is combinationally visible that cycle and held afterwards.
REQ-030 A MEM write grant SHALL set no tag and SHALL produce no rvalid.
REQ-031 Back-to-back grants SHALL be supported: the return for cycle N and the grant for cycle N+1 overlap with no bubble.

Reset
REQ-032 While rst=1, the following SHALL hold: state=ARB, starve counter=0, tag=0, if_rvalid=0, mem_rvalid=0, if_rdata=0, mem_rdata=0.
REQ-033 Asserting rst mid-operation SHALL discard any pending return; no rvalid SHALL assert in the cycle after reset deasserts.
REQ-034 The stall and SRAM outputs SHALL remain combinational functions of the request inputs and state during reset.

Verification
REQ-035 IF-only: if_req=1, if_addr=0x0010, SRAM word 0x00000013 -> if_stall=0, sram_addr=0x0010; next cycle if_rvalid=1, if_rdata=0x00000013.
REQ-036 Conflict: both requesting, mem_w_en=4'b1111, mem_addr=0x8000, mem_wdata=0xDEADBEEF -> MEM granted, if_stall=1, mem_stall=0, write performed, no mem_rvalid next cycle.
REQ-037 Starvation, STARVE_MAX=4: both requesting continuously -> MEM granted cycles 0-3, IF granted cycle 4 with mem_stall=1, MEM granted cycle 5, IF next forced at cycle 9.
REQ-038 Back-to-back reads: MEM read at 0x0100, then IF read at 0x0004 -> mem_rvalid then if_rvalid on consecutive cycles with the correct data, and each rdata holds afterwards.
REQ-039 Reset mid-read: rst asserted in the cycle after a MEM read grant -> mem_rvalid=0 and mem_rdata=0 immediately; no rvalid after release.
REQ-040 Idle: no requests -> sram_w_en=0, both stalls=0, starve counter stays 0.
